// File: rtl/snoop_responder_pkg.sv
// rtl/snoop_responder_pkg.sv - coherence message codes, MESI encoding and FSM states shared by the snoop agent
package snoop_responder_pkg;

  // Controller-to-cache broadcasts
  localparam logic [2:0] C_NO_REQ      = 3'd0;
  localparam logic [2:0] C_RD_BCAST    = 3'd1;
  localparam logic [2:0] C_WS_BCAST    = 3'd2;
  localparam logic [2:0] C_RFO_BCAST   = 3'd3;
  localparam logic [2:0] C_FLUSH_BCAST = 3'd4;
  localparam logic [2:0] C_INVLD_BCAST = 3'd5;
  localparam logic [2:0] ENABLE_WS     = 3'd6;

  // Cache-to-controller responses
  localparam logic [2:0] C_WB          = 3'd1;
  localparam logic [2:0] C_EN_ACCESS   = 3'd2;
  localparam logic [2:0] C_FLUSH       = 3'd3;
  localparam logic [2:0] C_INVLD       = 3'd4;

  // Memory-to-cache messages
  localparam logic [2:0] MEM_READY     = 3'd1;
  localparam logic [2:0] M_RECV        = 3'd2;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam int STATUS_VALID = 0;
  localparam int STATUS_DIRTY = 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_CHECK, ST_WB_WAIT, ST_ENABLED, ST_WS_HOLD
  } snoop_state_e;

  function automatic logic is_bcast(input logic [2:0] msg);
    return (msg == C_RD_BCAST) || (msg == C_RFO_BCAST) || (msg == C_WS_BCAST) ||
           (msg == C_FLUSH_BCAST) || (msg == C_INVLD_BCAST);
  endfunction

endpackage

// File: rtl/mesi_snoop_decode.sv
// rtl/mesi_snoop_decode.sv - combinational {message, hit, state} to {response, next state, data/write needs}
module mesi_snoop_decode
  import snoop_responder_pkg::*;
#(
  parameter int MSG_BITS       = 3,
  parameter int COHERENCE_BITS = 2
) (
  input  logic [MSG_BITS-1:0]       msg_i,
  input  logic                      hit_i,
  input  logic [COHERENCE_BITS-1:0] state_i,
  output logic [MSG_BITS-1:0]       resp_o,
  output logic [COHERENCE_BITS-1:0] next_state_o,
  output logic                      needs_data_o,
  output logic                      needs_wr_o
);

  always_comb begin
    resp_o       = C_EN_ACCESS;
    next_state_o = state_i;
    needs_data_o = 1'b0;
    needs_wr_o   = 1'b0;
    if (hit_i) begin
      if (state_i == MESI_M) begin
        // Dirty line leaves with the response; state write waits for memory
        needs_data_o = 1'b1;
        next_state_o = (msg_i == C_RD_BCAST) ? MESI_S : MESI_I;
        case (msg_i)
          C_FLUSH_BCAST: resp_o = C_FLUSH;
          C_INVLD_BCAST: resp_o = C_INVLD;
          default:       resp_o = C_WB;
        endcase
      end else if (msg_i == C_RD_BCAST) begin
        if (state_i == MESI_E) begin
          next_state_o = MESI_S;
          needs_wr_o   = 1'b1;
        end
      end else begin
        next_state_o = MESI_I;
        needs_wr_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - MESI snoop agent for one cache; SNOOP_STATS_EN adds hit/miss/writeback counters
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int STATUS_BITS    = 2,
  parameter int COHERENCE_BITS = 2,
  parameter int OFFSET_BITS    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 12,
  parameter int MSG_BITS       = 3,
  parameter int INDEX_BITS     = 4,
  localparam int WORDS_PER_LINE = 1 << OFFSET_BITS,
  localparam int LINE_WIDTH     = DATA_WIDTH * WORDS_PER_LINE,
  localparam int BUS_WIDTH      = STATUS_BITS + COHERENCE_BITS + LINE_WIDTH,
  localparam int TAG_BITS       = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [MSG_BITS-1:0]       bus_msg_in,
  input  logic [ADDRESS_WIDTH-1:0]  bus_address_in,
  input  logic [MSG_BITS-1:0]       mem_msg_in,
  output logic [MSG_BITS-1:0]       resp_msg_out,
  output logic [BUS_WIDTH-1:0]      resp_data_out,
  output logic                      snoop_rd_en,
  output logic [INDEX_BITS-1:0]     snoop_index,
  input  logic [TAG_BITS-1:0]       snoop_tag_in,
  input  logic [COHERENCE_BITS-1:0] snoop_state_in,
  input  logic [STATUS_BITS-1:0]    snoop_status_in,
  input  logic [LINE_WIDTH-1:0]     snoop_line_in,
  output logic                      snoop_wr_en,
  output logic [COHERENCE_BITS-1:0] snoop_state_out,
  output logic [STATUS_BITS-1:0]    snoop_status_out,
  output logic                      snoop_busy,
  output logic                      ws_enable
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]               stat_hits,
  output logic [15:0]               stat_misses,
  output logic [15:0]               stat_writebacks
`endif
);

  snoop_state_e                state_q, state_d;
  logic [MSG_BITS-1:0]         msg_q, msg_d;
  logic [MSG_BITS-1:0]         resp_q, resp_d;
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [BUS_WIDTH-1:0]        data_q, data_d;
  logic [COHERENCE_BITS-1:0]   wb_state_q, wb_state_d;

  logic                        hit, abort, wb_done;
  logic [MSG_BITS-1:0]         dec_resp;
  logic [COHERENCE_BITS-1:0]   dec_next_state;
  logic                        dec_needs_data, dec_needs_wr;
  logic                        unused_addr;

  assign unused_addr = ^addr_q[OFFSET_BITS-1:0];
  assign abort   = (bus_msg_in == C_NO_REQ);
  assign hit     = (snoop_tag_in == addr_q[ADDRESS_WIDTH-1 -: TAG_BITS]) &&
                   snoop_status_in[STATUS_VALID] && (snoop_state_in != MESI_I);
  assign wb_done = (resp_q == C_WB) ? (mem_msg_in == MEM_READY) : (mem_msg_in == M_RECV);

  mesi_snoop_decode #(
    .MSG_BITS       (MSG_BITS),
    .COHERENCE_BITS (COHERENCE_BITS)
  ) u_decode (
    .msg_i        (msg_q),
    .hit_i        (hit),
    .state_i      (snoop_state_in),
    .resp_o       (dec_resp),
    .next_state_o (dec_next_state),
    .needs_data_o (dec_needs_data),
    .needs_wr_o   (dec_needs_wr)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_bcast(bus_msg_in))            state_d = ST_READ;
        else if (bus_msg_in == ENABLE_WS)    state_d = ST_WS_HOLD;
      end
      ST_READ:    state_d = abort ? ST_IDLE : ST_CHECK;
      ST_CHECK:   state_d = abort ? ST_IDLE : (dec_needs_data ? ST_WB_WAIT : ST_ENABLED);
      ST_WB_WAIT: if (wb_done) state_d = ST_ENABLED;
      ST_ENABLED, ST_WS_HOLD: if (abort) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    msg_d      = msg_q;
    addr_d     = addr_q;
    resp_d     = resp_q;
    data_d     = data_q;
    wb_state_d = wb_state_q;
    case (state_q)
      ST_IDLE: if (is_bcast(bus_msg_in)) begin
        msg_d  = bus_msg_in;
        addr_d = bus_address_in;
      end
      ST_CHECK: if (!abort) begin
        resp_d     = dec_resp;
        data_d     = dec_needs_data ? {snoop_status_in, snoop_state_in, snoop_line_in} : '0;
        wb_state_d = dec_next_state;
      end
      ST_WB_WAIT: if (wb_done) begin
        resp_d = C_EN_ACCESS;
        data_d = '0;
      end
      ST_ENABLED: if (abort) resp_d = C_NO_REQ;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      msg_q      <= C_NO_REQ;
      addr_q     <= '0;
      resp_q     <= C_NO_REQ;
      data_q     <= '0;
      wb_state_q <= MESI_I;
    end else begin
      msg_q      <= msg_d;
      addr_q     <= addr_d;
      resp_q     <= resp_d;
      data_q     <= data_d;
      wb_state_q <= wb_state_d;
    end
  end

  always_comb begin
    resp_msg_out     = resp_q;
    resp_data_out    = data_q;
    snoop_rd_en      = (state_q == ST_READ);
    snoop_index      = addr_q[OFFSET_BITS +: INDEX_BITS];
    snoop_busy       = (state_q != ST_IDLE);
    ws_enable        = (state_q == ST_WS_HOLD);
    snoop_wr_en      = 1'b0;
    snoop_state_out  = MESI_I;
    snoop_status_out = '0;
    if (state_q == ST_CHECK) begin
      snoop_wr_en     = dec_needs_wr && !abort;
      snoop_state_out = dec_next_state;
    end else if (state_q == ST_WB_WAIT) begin
      snoop_wr_en     = wb_done;
      snoop_state_out = wb_state_q;
    end
    // Surviving lines are always clean after a snoop
    if (snoop_state_out != MESI_I) snoop_status_out[STATUS_VALID] = 1'b1;
    if (reset) snoop_wr_en = 1'b0;
  end

`ifdef SNOOP_STATS_EN
  logic [15:0] hits_q, misses_q, wbs_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      if (state_q == ST_CHECK && !abort) begin
        if (hit && hits_q != 16'hFFFF)         hits_q   <= hits_q + 16'd1;
        else if (!hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
      end
      if (state_q == ST_WB_WAIT && wb_done && wbs_q != 16'hFFFF) wbs_q <= wbs_q + 16'd1;
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - directed self-checking bench for snoop_responder
module tb_snoop_responder;
  import snoop_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  bus_msg_in, mem_msg_in, resp_msg_out;
  logic [11:0] bus_address_in;
  logic [35:0] resp_data_out;
  logic        snoop_rd_en, snoop_wr_en, snoop_busy, ws_enable;
  logic [3:0]  snoop_index;
  logic [5:0]  snoop_tag_in;
  logic [1:0]  snoop_state_in, snoop_status_in, snoop_state_out, snoop_status_out;
  logic [31:0] snoop_line_in;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  snoop_responder dut (
    .clock(clock), .reset(reset),
    .bus_msg_in(bus_msg_in), .bus_address_in(bus_address_in), .mem_msg_in(mem_msg_in),
    .resp_msg_out(resp_msg_out), .resp_data_out(resp_data_out),
    .snoop_rd_en(snoop_rd_en), .snoop_index(snoop_index),
    .snoop_tag_in(snoop_tag_in), .snoop_state_in(snoop_state_in),
    .snoop_status_in(snoop_status_in), .snoop_line_in(snoop_line_in),
    .snoop_wr_en(snoop_wr_en), .snoop_state_out(snoop_state_out),
    .snoop_status_out(snoop_status_out), .snoop_busy(snoop_busy), .ws_enable(ws_enable)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_array(input logic [5:0] tag, input logic [1:0] st,
                           input logic [1:0] status, input logic [31:0] line);
    snoop_tag_in = tag; snoop_state_in = st; snoop_status_in = status; snoop_line_in = line;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_msg_in = C_NO_REQ; bus_address_in = '0; mem_msg_in = 3'd0;
    set_array(6'd0, MESI_I, 2'b00, 32'd0);
    tick(); tick();
    reset = 1'b0; #1;
    tests++; if (resp_msg_out !== C_NO_REQ) begin fails++; $display("FAIL reset_resp: got %0d want %0d", resp_msg_out, C_NO_REQ); end
    tests++; if (resp_data_out !== 36'd0) begin fails++; $display("FAIL reset_data: got %0h want 0", resp_data_out); end
    tests++; if ({snoop_busy, snoop_rd_en, snoop_wr_en, ws_enable} !== 4'b0000) begin fails++; $display("FAIL reset_strobes: got %b want 0000", {snoop_busy, snoop_rd_en, snoop_wr_en, ws_enable}); end
  endtask

  task automatic test_miss();
    bus_msg_in = C_RD_BCAST; bus_address_in = 12'h0A4;
    tick(); // READ
    set_array(6'd3, MESI_E, 2'b01, 32'h1234_5678);
    tests++; if (snoop_rd_en !== 1'b1) begin fails++; $display("FAIL miss_rd_en: got %b want 1", snoop_rd_en); end
    tests++; if (snoop_index !== 4'd9) begin fails++; $display("FAIL miss_index: got %0d want 9", snoop_index); end
    tick(); // CHECK
    tests++; if (snoop_wr_en !== 1'b0) begin fails++; $display("FAIL miss_no_wr: got %b want 0", snoop_wr_en); end
    tick(); // ENABLED
    tests++; if (resp_msg_out !== C_EN_ACCESS) begin fails++; $display("FAIL miss_en_access: got %0d want %0d", resp_msg_out, C_EN_ACCESS); end
    bus_msg_in = C_NO_REQ;
    tick();
    tests++; if (resp_msg_out !== C_NO_REQ || snoop_busy !== 1'b0) begin fails++; $display("FAIL miss_release: got resp %0d busy %b want %0d 0", resp_msg_out, snoop_busy, C_NO_REQ); end
  endtask

  task automatic test_rd_exclusive();
    bus_msg_in = C_RD_BCAST; bus_address_in = 12'h0A4;
    tick();
    set_array(6'd2, MESI_E, 2'b01, 32'h0);
    tick(); // CHECK
    tests++; if (snoop_wr_en !== 1'b1 || snoop_state_out !== MESI_S || snoop_status_out !== 2'b01) begin fails++; $display("FAIL rd_e_write: got wr %b st %0d status %b want 1 1 01", snoop_wr_en, snoop_state_out, snoop_status_out); end
    tick();
    tests++; if (resp_msg_out !== C_EN_ACCESS || snoop_wr_en !== 1'b0) begin fails++; $display("FAIL rd_e_resp: got %0d wr %b want %0d 0", resp_msg_out, snoop_wr_en, C_EN_ACCESS); end
    bus_msg_in = C_NO_REQ;
    tick();
  endtask

  task automatic test_rd_modified();
    bus_msg_in = C_RD_BCAST; bus_address_in = 12'h0A4;
    tick();
    set_array(6'd2, MESI_M, 2'b11, 32'hDEAD_BEEF);
    tick(); // CHECK
    tests++; if (snoop_wr_en !== 1'b0) begin fails++; $display("FAIL rd_m_check_wr: got %b want 0", snoop_wr_en); end
    tick(); // WB_WAIT cycle 1
    tests++; if (resp_data_out !== {2'b11, 2'd3, 32'hDEAD_BEEF}) begin fails++; $display("FAIL rd_m_data: got %h want %h", resp_data_out, {2'b11, 2'd3, 32'hDEAD_BEEF}); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (resp_msg_out !== C_WB || snoop_wr_en !== 1'b0) begin fails++; $display("FAIL rd_m_hold%0d: got %0d wr %b want %0d 0", i, resp_msg_out, snoop_wr_en, C_WB); end
      tick();
    end
    mem_msg_in = MEM_READY; #1;
    tests++; if (snoop_wr_en !== 1'b1 || snoop_state_out !== MESI_S || snoop_status_out !== 2'b01) begin fails++; $display("FAIL rd_m_wb_write: got wr %b st %0d status %b want 1 1 01", snoop_wr_en, snoop_state_out, snoop_status_out); end
    tick();
    mem_msg_in = 3'd0; #1;
    tests++; if (resp_msg_out !== C_EN_ACCESS || snoop_wr_en !== 1'b0) begin fails++; $display("FAIL rd_m_en: got %0d wr %b want %0d 0", resp_msg_out, snoop_wr_en, C_EN_ACCESS); end
    bus_msg_in = C_NO_REQ;
    tick();
  endtask

  task automatic test_invalidate();
    bus_msg_in = C_INVLD_BCAST; bus_address_in = 12'h0A4;
    tick();
    set_array(6'd2, MESI_S, 2'b01, 32'h0);
    tick();
    tests++; if (snoop_wr_en !== 1'b1 || snoop_state_out !== MESI_I || snoop_status_out !== 2'b00) begin fails++; $display("FAIL invld_s_write: got wr %b st %0d status %b want 1 0 00", snoop_wr_en, snoop_state_out, snoop_status_out); end
    tick();
    tests++; if (resp_msg_out !== C_EN_ACCESS) begin fails++; $display("FAIL invld_s_resp: got %0d want %0d", resp_msg_out, C_EN_ACCESS); end
    bus_msg_in = C_NO_REQ;
    tick();
    bus_msg_in = C_FLUSH_BCAST; bus_address_in = 12'h0A4;
    tick();
    set_array(6'd2, MESI_M, 2'b11, 32'hCAFE_F00D);
    tick(); tick(); // WB_WAIT
    mem_msg_in = MEM_READY; #1;
    tests++; if (resp_msg_out !== C_FLUSH || snoop_wr_en !== 1'b0) begin fails++; $display("FAIL flush_wrong_ack: got %0d wr %b want %0d 0", resp_msg_out, snoop_wr_en, C_FLUSH); end
    tick();
    mem_msg_in = M_RECV; #1;
    tests++; if (snoop_wr_en !== 1'b1 || snoop_state_out !== MESI_I || snoop_status_out !== 2'b00) begin fails++; $display("FAIL flush_write: got wr %b st %0d status %b want 1 0 00", snoop_wr_en, snoop_state_out, snoop_status_out); end
    tick();
    mem_msg_in = 3'd0; #1;
    tests++; if (resp_msg_out !== C_EN_ACCESS) begin fails++; $display("FAIL flush_en: got %0d want %0d", resp_msg_out, C_EN_ACCESS); end
    bus_msg_in = C_NO_REQ;
    tick();
  endtask

  task automatic test_ws_passthrough();
    bus_msg_in = ENABLE_WS; #1;
    tests++; if (ws_enable !== 1'b0) begin fails++; $display("FAIL ws_early: got %b want 0", ws_enable); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) bus_msg_in = C_NO_REQ;
      tests++; if (ws_enable !== 1'b1) begin fails++; $display("FAIL ws_hold%0d: got %b want 1", i, ws_enable); end
    end
    tick();
    tests++; if (ws_enable !== 1'b0 || snoop_busy !== 1'b0) begin fails++; $display("FAIL ws_release: got ws %b busy %b want 0 0", ws_enable, snoop_busy); end
  endtask

  task automatic test_abort();
    bus_msg_in = C_RD_BCAST; bus_address_in = 12'h0A4;
    tick();
    set_array(6'd2, MESI_E, 2'b01, 32'h0);
    tick(); // CHECK
    bus_msg_in = C_NO_REQ; #1;
    tests++; if (snoop_wr_en !== 1'b0) begin fails++; $display("FAIL abort_wr: got %b want 0", snoop_wr_en); end
    tick();
    tests++; if (snoop_busy !== 1'b0 || resp_msg_out !== C_NO_REQ) begin fails++; $display("FAIL abort_idle: got busy %b resp %0d want 0 %0d", snoop_busy, resp_msg_out, C_NO_REQ); end
  endtask

  task automatic test_reset_mid_wb();
    bus_msg_in = C_RD_BCAST; bus_address_in = 12'h0A4;
    tick();
    set_array(6'd2, MESI_M, 2'b11, 32'h0BAD_F00D);
    tick(); tick(); // WB_WAIT
    tests++; if (resp_msg_out !== C_WB) begin fails++; $display("FAIL rst_wb_pre: got %0d want %0d", resp_msg_out, C_WB); end
    reset = 1'b1; bus_msg_in = C_NO_REQ; mem_msg_in = MEM_READY; #1;
    tests++; if (snoop_wr_en !== 1'b0) begin fails++; $display("FAIL rst_wb_wr: got %b want 0", snoop_wr_en); end
    tick();
    reset = 1'b0; mem_msg_in = 3'd0; #1;
    tests++; if (resp_msg_out !== C_NO_REQ || snoop_busy !== 1'b0 || resp_data_out !== 36'd0) begin fails++; $display("FAIL rst_wb_after: got resp %0d busy %b data %h want %0d 0 0", resp_msg_out, snoop_busy, resp_data_out, C_NO_REQ); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_miss();
    test_rd_exclusive();
    test_rd_modified();
    test_invalidate();
    test_ws_passthrough();
    test_abort();
    test_reset_mid_wb();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
